// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: turns hazard stalls, ID/EX redirects and the data-memory
// ready handshake into per-stage load enables and bubble flushes for the
// 5-stage core. It tracks multi-cycle memory waits with a RUN/WAIT machine
// and a sticky watchdog, and keeps saturating performance counters.
module pipeline_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16   // legal range 2..255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hz_stall,
  input  logic             id_redirect,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             id_ex_we,
  output logic             ex_mem_we,
  output logic             mem_wb_we,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wait,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Which priority rule governs the current cycle; drives both the control
  // outputs and the performance counters so they can never disagree.
  typedef enum logic [2:0] {
    RULE_RESET,
    RULE_FREEZE,
    RULE_EX_REDIRECT,
    RULE_STALL,
    RULE_ID_REDIRECT,
    RULE_NORMAL
  } rule_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [7:0]       WAIT_MAX  = 8'hFF;
  localparam logic [7:0]       TIMEOUT_C = 8'(TIMEOUT);

  state_t     state;
  logic [7:0] wait_cnt;
  logic [7:0] wait_cnt_inc;
  logic       freeze;
  rule_t      rule;

  // An outstanding access that is not completing this cycle freezes the
  // whole pipe, in RUN and in WAIT alike.
  assign freeze = mem_req & ~mem_ready;

  assign mem_wait = (state == ST_WAIT);

  assign wait_cnt_inc = (wait_cnt == WAIT_MAX) ? WAIT_MAX : wait_cnt + 8'd1;

  // Pick the first matching rule in priority order.
  always_comb begin
    // NOTE: default assignment first so no path leaves rule unassigned (no latch).
    rule = RULE_NORMAL;
    if (rst)              rule = RULE_RESET;
    else if (freeze)      rule = RULE_FREEZE;
    else if (ex_redirect) rule = RULE_EX_REDIRECT;
    else if (hz_stall)    rule = RULE_STALL;   // a stalled branch is not resolved yet
    else if (id_redirect) rule = RULE_ID_REDIRECT;
  end

  // Decode the governing rule into enables and flushes; a flushed register
  // is always also enabled so the bubble actually loads.
  always_comb begin
    pc_we       = 1'b0;
    if_id_we    = 1'b0;
    id_ex_we    = 1'b0;
    ex_mem_we   = 1'b0;
    mem_wb_we   = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    unique case (rule)
      RULE_RESET, RULE_FREEZE: ;
      RULE_EX_REDIRECT: begin
        {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 5'b11111;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end
      RULE_STALL: begin
        {id_ex_we, ex_mem_we, mem_wb_we} = 3'b111;
        id_ex_flush = 1'b1;
      end
      RULE_ID_REDIRECT: begin
        {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 5'b11111;
        if_id_flush = 1'b1;
      end
      default: begin
        {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 5'b11111;
      end
    endcase
  end

  // RUN/WAIT machine with the consecutive-freeze watchdog.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all clocked state so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state       <= ST_RUN;
      wait_cnt    <= 8'd0;
      mem_timeout <= 1'b0;
    end else begin
      unique case (state)
        ST_RUN:  if (freeze)  state <= ST_WAIT;
        ST_WAIT: if (!freeze) state <= ST_RUN;   // mem_req=0 here is treated as ready
        default: state <= ST_RUN;
      endcase
      if (freeze) begin
        wait_cnt <= wait_cnt_inc;
        if (wait_cnt_inc >= TIMEOUT_C) mem_timeout <= 1'b1;
      end else begin
        wait_cnt <= 8'd0;
      end
    end
  end

  // Saturating performance counters, one event class per counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
      freeze_cnt <= '0;
    end else begin
      if (rule == RULE_STALL && bubble_cnt != CNT_MAX)
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      if ((rule == RULE_EX_REDIRECT || rule == RULE_ID_REDIRECT) && flush_cnt != CNT_MAX)
        flush_cnt <= flush_cnt + CNT_W'(1);
      if (rule == RULE_FREEZE && freeze_cnt != CNT_MAX)
        freeze_cnt <= freeze_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
module tb_pipeline_ctrl;

  localparam int CNT_W   = 6;
  localparam int TIMEOUT = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst, hz_stall, id_redirect, ex_redirect, mem_req, mem_ready;
  logic pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_flush;
  logic mem_wait, mem_timeout;
  logic [CNT_W-1:0] bubble_cnt, flush_cnt, freeze_cnt;

  always #5 clk = ~clk;

  pipeline_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .hz_stall(hz_stall), .id_redirect(id_redirect), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we),
    .ex_mem_we(ex_mem_we), .mem_wb_we(mem_wb_we),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_wait(mem_wait), .mem_timeout(mem_timeout),
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Model state: what the registered outputs should show right now.
  bit m_wait, m_timeout;
  int m_frozen_run;
  int m_bubble, m_flush, m_freeze;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  // One clock cycle: drive inputs, compare every output against the model,
  // then advance the model across the rising edge.
  task automatic step(input bit r, input bit hs, input bit idr, input bit exr,
                      input bit rq, input bit rdy);
    logic [6:0] exp_ctrl;
    bit frz;
    int cls;   // 0 none, 1 bubble, 2 flush, 3 freeze
    @(negedge clk);
    rst = r; hz_stall = hs; id_redirect = idr; ex_redirect = exr;
    mem_req = rq; mem_ready = rdy;
    #1;
    frz = rq && !rdy;
    cls = 0;
    // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}
    if (r)        exp_ctrl = 7'b0000000;
    else if (frz) begin exp_ctrl = 7'b0000000; cls = 3; end
    else if (exr) begin exp_ctrl = 7'b1111111; cls = 2; end
    else if (hs)  begin exp_ctrl = 7'b0011101; cls = 1; end
    else if (idr) begin exp_ctrl = 7'b1111110; cls = 2; end
    else          exp_ctrl = 7'b1111100;
    check("ctrl", {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_flush},
          exp_ctrl);
    check("mem_wait", mem_wait, m_wait);
    check("mem_timeout", mem_timeout, m_timeout);
    check("bubble_cnt", bubble_cnt, m_bubble);
    check("flush_cnt", flush_cnt, m_flush);
    check("freeze_cnt", freeze_cnt, m_freeze);
    @(posedge clk);
    if (r) begin
      m_wait = 0; m_timeout = 0; m_frozen_run = 0;
      m_bubble = 0; m_flush = 0; m_freeze = 0;
    end else begin
      m_wait = frz;
      m_frozen_run = frz ? m_frozen_run + 1 : 0;
      if (m_frozen_run >= TIMEOUT) m_timeout = 1;
      if (cls == 1) m_bubble = sat_inc(m_bubble);
      if (cls == 2) m_flush  = sat_inc(m_flush);
      if (cls == 3) m_freeze = sat_inc(m_freeze);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; hz_stall = 0; id_redirect = 0; ex_redirect = 0; mem_req = 0; mem_ready = 0;
    m_wait = 0; m_timeout = 0; m_frozen_run = 0;
    m_bubble = 0; m_flush = 0; m_freeze = 0;
    @(posedge clk);

    // Reset, then idle.
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    idle(3);

    // Two stall cycles.
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    #1 check("plan_bubble2", bubble_cnt, 2);

    // All three requests together: ex_redirect wins.
    step(0, 1, 1, 1, 0, 0);
    #1 check("plan_flush1", flush_cnt, 1);
    check("plan_bubble_kept", bubble_cnt, 2);

    // Three-cycle memory wait then completion.
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 1, 1, 0, 1, 0);
    #1 check("plan_wait_high", mem_wait, 1);
    step(0, 0, 0, 0, 1, 1);
    #1 check("plan_freeze3", freeze_cnt, 3);
    check("plan_no_timeout", mem_timeout, 0);

    // Single-cycle access: no freeze, no state change.
    step(0, 0, 0, 0, 1, 1);
    #1 check("single_cycle_wait", mem_wait, 0);

    // Watchdog: six frozen cycles, then ready; stays set until reset.
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 0);
    #1 check("plan_timeout_set", mem_timeout, 1);
    step(0, 0, 0, 0, 1, 1);
    idle(2);
    #1 check("plan_timeout_sticky", mem_timeout, 1);

    // Reset in the middle of WAIT.
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 0);
    #1 check("plan_rst_timeout", mem_timeout, 0);
    check("plan_rst_wait", mem_wait, 0);
    check("plan_rst_freeze_cnt", freeze_cnt, 0);
    step(0, 0, 0, 0, 1, 1);

    // mem_req dropped in WAIT counts as ready.
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0, 0);
    idle(1);

    // Randomized traffic with occasional resets; long stretches without
    // reset drive the narrow counters into saturation.
    for (int i = 0; i < 4000; i++) begin
      bit r, hs, idr, exr, rq, rdy;
      r   = ($urandom_range(0, 599) == 0);
      hs  = ($urandom_range(0, 3) == 0);
      idr = ($urandom_range(0, 3) == 0);
      exr = ($urandom_range(0, 5) == 0);
      rq  = ($urandom_range(0, 2) != 0);
      rdy = ($urandom_range(0, 9) < ((i / 500) % 2 == 0 ? 6 : 2));
      step(r, hs, idr, exr, rq, rdy);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute bound on run time in case the clocking ever stalls.
  initial begin
    #1000000;
    $display("FAIL watchdog_time got=timeout exp=finish");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Pipeline control responder for the 5-stage RISC-V core: consumes the hazard unit's stall request, branch/jump redirect requests from ID and EX, and the data-memory ready handshake. It converts them into per-stage write-enable and flush (bubble) controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It tracks multi-cycle memory waits with a state machine and watchdog, and keeps saturating performance counters.

## Interface
- CNT_W, 32, width of each performance counter
- TIMEOUT, 16, consecutive frozen cycles before mem_timeout sets (legal range 2..255)
- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- hz_stall  in  1  load-use/branch-operand stall request from hazard detection
- id_redirect  in  1  branch taken / jal resolved in ID
- ex_redirect  in  1  jalr resolved in EX
- mem_req  in  1  EX/MEM holds a valid load or store
- mem_ready  in  1  data memory completes the access this cycle
- pc_we  out  1  PC register load enable
- if_id_we, id_ex_we, ex_mem_we, mem_wb_we  out  1 each  stage register load enables
- if_id_flush, id_ex_flush  out  1 each  stage register loads a NOP bubble at next edge
- mem_wait  out  1  high while state is WAIT
- mem_timeout  out  1  sticky watchdog error
- bubble_cnt, flush_cnt, freeze_cnt  out  CNT_W each  performance counters

## Operation
- States: RUN, WAIT. Reset state RUN.
- Control outputs are evaluated by the first matching rule, in this priority order:
  1. rst=1: all *_we=0, all flushes=0.
  2. Freeze: RUN with mem_req&!mem_ready, or WAIT with mem_req&!mem_ready. All *_we=0 and flushes=0. All redirects and stalls are ignored; the frozen stages hold them.
  3. ex_redirect: pc_we=1, if_id_flush=1, id_ex_flush=1, remaining enables=1.
  4. hz_stall: pc_we=0, if_id_we=0, id_ex_flush=1, ex_mem_we=mem_wb_we=1.
  5. id_redirect: pc_we=1, if_id_flush=1, remaining enables=1.
  6. Normal: all *_we=1, flushes=0.
- When a flush is 1, the corresponding *_we is also 1. A flush always wins over hold.
- hz_stall masks id_redirect: a stalled branch is not yet resolved.
- Transitions:
  - RUN→WAIT on freeze.
  - WAIT→RUN when mem_ready=1 or mem_req=0; that cycle applies rules 3-6.
  - mem_req=0 in WAIT is a protocol violation and is treated as ready.
- Watchdog:
  - wait_cnt (8 bits) = consecutive frozen cycles including the current one. It is cleared to 0 on any non-frozen cycle.
  - mem_timeout sets at the edge ending the TIMEOUT-th consecutive frozen cycle, and stays set until rst.
  - The freeze continues regardless; no auto-recovery.
- Counters: +1 per cycle, saturating at 2^CNT_W-1.
  - bubble_cnt increments on cycles where rule 4 applies.
  - flush_cnt increments on cycles where rule 3 or 5 applies.
  - freeze_cnt increments on cycles where rule 2 applies.

## Timing
- All control outputs are combinational from inputs and state; zero-cycle latency.
- State, wait_cnt, counters and mem_timeout are registered and update on the rising edge of clk.
- Reset values:
  - state RUN, mem_wait=0, mem_timeout=0, wait_cnt=0, all counters 0.
  - During rst, control outputs follow rule 1.
- Reset mid-WAIT: the next cycle after rst falls is RUN with a cleared watchdog. If mem_req&!mem_ready is still present, re-entry into WAIT follows the normal RUN rules.
- Freeze in RUN takes effect the same cycle mem_req&!mem_ready first appears; mem_wait rises one cycle later.
- A single-cycle memory access (mem_ready=1 on the first mem_req cycle) causes no freeze and no state change.
- Simultaneous ex_redirect+hz_stall+id_redirect resolves to rule 3 and counts only in flush_cnt.

## Test plan
- Reset, then idle inputs for 3 cycles → all *_we=1, flushes=0, counters 0, mem_wait=0.
- hz_stall=1 for 2 cycles → pc_we=if_id_we=0, id_ex_flush=1 each cycle; bubble_cnt=2.
- ex_redirect=1, hz_stall=1, id_redirect=1 for 1 cycle → pc_we=1, if_id_flush=id_ex_flush=1; flush_cnt=1, bubble_cnt unchanged.
- mem_req=1 with mem_ready=0 for 3 cycles then 1 → all enables 0 for 3 cycles, mem_wait high on cycles 2-4, back to RUN with enables=1 on cycle 4; freeze_cnt=3, mem_timeout=0.
- TIMEOUT=4, mem_ready held 0 for 6 cycles → mem_timeout=1 after edge 4, stays 1 after mem_ready=1; only rst clears it.
- rst=1 asserted in WAIT (cycle 2 of freeze) → next cycle state RUN, counters 0, mem_timeout=0; with mem_ready=1 on that cycle, enables=1.
